minsoc_clock_reset_ctrl: RTL and testbench
==========================================

# minsoc_clock_reset_ctrl

Synthesisable, parametrised clock/reset controller for the minsoc top level. It produces the system reset of configurable polarity from the board reset with a fixed hold time, and an optional software-requested reset. It also generates NUM_CH independently programmable divided clocks, for example Ethernet PHY tx/rx clocks, from the single system clock. It replaces free-running per-clock generators with one block that has a defined reset release order.

## Interface
Parameters:
- NUM_CH, 2: number of divided-clock channels (1..8).
- DIV_W, 8: width of each channel divisor.
- RST_HOLD, 16: cycles rst_o stays asserted after synchronised reset release or a software request (≥1).
- RST_POL, 1'b1: active level of rst_o and rst_ch_o; 1 = POSITIVE_RESET, 0 = NEGATIVE_RESET.

Ports:
- clock, in, 1: system clock; all logic is on the rising edge.
- reset, in, 1: asynchronous, active-low reset.
- sw_rst_i, in, 1: software reset request, level-sampled.
- en_i, in, NUM_CH: per-channel divider enable.
- div_i, in, NUM_CH*DIV_W: per-channel half-period minus one; channel k uses bits [k*DIV_W +: DIV_W].
- rst_o, out, 1: system reset, level RST_POL while asserted.
- rst_ch_o, out, NUM_CH: per-channel reset, level RST_POL while asserted.
- clk_o, out, NUM_CH: divided clocks, registered outputs.
- tick_o, out, NUM_CH: one-cycle pulse on each clk_o falling toggle, marking a period boundary.
- ready_o, out, 1: high in RUN.

## Operation
- Reset synchroniser: two flops. Both clear asynchronously on reset low and load 1 on release.
- FSM states: HOLD, STAGGER, RUN.
  - reset low forces HOLD with hold counter = 0, all resets asserted, clk_o = 0, tick_o = 0, and all divider counters = 0.
  - HOLD: the counter increments only while the synchroniser output is 1. When the counter reaches RST_HOLD-1, rst_o deasserts and the FSM moves to STAGGER.
  - STAGGER: rst_ch_o[k] deasserts k+1 cycles after rst_o. After rst_ch_o[NUM_CH-1] deasserts, the FSM moves to RUN.
  - RUN: ready_o = 1. If sw_rst_i = 1 in RUN, the FSM moves to HOLD on the next edge: counter = 0, rst_o and all rst_ch_o reasserted, dividers cleared.
  - sw_rst_i is ignored in HOLD and STAGGER. It does not extend the hold.
- Divider for channel k:
  - Active only when rst_ch_o[k] is deasserted and en_i[k] = 1.
  - The counter counts 0..D. At D, the counter returns to 0 and clk_o[k] toggles.
  - The clk_o period is 2*(D+1) cycles. D = 0 gives clock/2.
  - D is the latched divisor. The latch loads div_i[k] only when the counter is at D on a cycle where clk_o[k] toggles 1→0, and also on the first enabled cycle. Therefore no half-period is ever truncated or stretched.
  - tick_o[k] is 1 for the cycle following the 1→0 toggle.
  - en_i[k] falling: the counter and clk_o[k] clear on the next edge. A partial high phase may be truncated, which is accepted. The latched divisor reloads on re-enable.
- Channels are fully independent. Changing div_i of one channel never affects another.

## Timing
- All outputs are registered. Nothing is combinational from inputs to outputs.
- Power-up release with NUM_CH = 2 and RST_HOLD = 16:
  - reset sampled high at edge 0.
  - Synchroniser output is 1 after edge 2.
  - rst_o deasserts after edge 2+RST_HOLD = 18.
  - rst_ch_o[0] deasserts at 19, rst_ch_o[1] at 20.
  - ready_o = 1 at 20.
- First clk_o[k] rise: D+1 cycles after the first enabled cycle.
- sw_rst_i sampled in RUN: rst_o asserts on the next edge. It deasserts RST_HOLD edges later, with no synchroniser delay.
- reset low mid-operation: all outputs go to reset values immediately, asynchronously.

## Configuration
- MINSOC_RST_STAGGER_EN defined: staged per-channel release as described above.
- MINSOC_RST_STAGGER_EN undefined:
  - STAGGER is skipped.
  - All rst_ch_o deassert on the same edge as rst_o.
  - The FSM goes HOLD→RUN, and ready_o rises on that edge.

## Test plan
- Power-up, RST_POL = 1, RST_HOLD = 16, stagger enabled: rst_o falls at edge 18, rst_ch_o[0] at 19, rst_ch_o[1] at 20, ready_o = 1 at 20. With the macro undefined, all three fall and ready_o rises at 18.
- Divider, div = 0 and div = 3 on channels 0/1: clk_o periods are 2 and 8 cycles at 50% duty, and tick_o pulses once per period.
- div_i changed 3→1 mid-high-phase: the current period completes at 8 cycles, the next period is 4 cycles, and no high or low phase is shorter than 2.
- sw_rst_i pulsed 1 cycle in RUN: rst_o asserts next edge for exactly 16 cycles, clk_o cleared, then normal restaging. sw_rst_i held high during HOLD is ignored.
- reset dropped low mid-HOLD and mid-RUN: outputs return to reset values with no clock edge, and the full 18-cycle sequence is restarted on release.
- RST_POL = 0: identical sequences with inverted rst_o and rst_ch_o levels.

Source files
------------

// File: rtl/minsoc_clock_reset_ctrl.sv
// Clock/reset controller: synchronised board reset with fixed hold, software reset, NUM_CH divided clocks.
// Define MINSOC_RST_STAGGER_EN for staged per-channel reset release; undefined releases all resets together.
module minsoc_clock_reset_ctrl #(
    parameter int   NUM_CH   = 2,
    parameter int   DIV_W    = 8,
    parameter int   RST_HOLD = 16,
    parameter logic RST_POL  = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    sw_rst_i,
    input  logic [NUM_CH-1:0]       en_i,
    input  logic [NUM_CH*DIV_W-1:0] div_i,
    output logic                    rst_o,
    output logic [NUM_CH-1:0]       rst_ch_o,
    output logic [NUM_CH-1:0]       clk_o,
    output logic [NUM_CH-1:0]       tick_o,
    output logic                    ready_o
);
    // state   | meaning
    // HOLD    | all resets asserted, hold counter running while synchroniser is 1
    // STAGGER | rst_o released, channel resets released one per cycle
    // RUN     | everything released, sw_rst_i honoured
    typedef enum logic [1:0] {ST_HOLD, ST_STAGGER, ST_RUN} state_t;

    localparam int HC_W = $clog2(RST_HOLD) + 1;
    localparam int SG_W = 3;

    state_t            state_q, state_d;
    logic [HC_W-1:0]   hold_q, hold_d;
    logic [1:0]        sync_q;
    logic              rst_run_q, rst_run_d;
    logic              ready_q, ready_d;
    logic [NUM_CH-1:0] ch_run_q, ch_run_d;
`ifdef MINSOC_RST_STAGGER_EN
    logic [SG_W-1:0]   stg_q, stg_d;
`endif

    // Outputs are registered from the next-state decode so they change on the same edge as the FSM.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q    <= '0;
            state_q   <= ST_HOLD;
            hold_q    <= '0;
            rst_run_q <= 1'b0;
            ready_q   <= 1'b0;
            ch_run_q  <= '0;
`ifdef MINSOC_RST_STAGGER_EN
            stg_q     <= '0;
`endif
        end else begin
            sync_q    <= {sync_q[0], 1'b1};
            state_q   <= state_d;
            hold_q    <= hold_d;
            rst_run_q <= rst_run_d;
            ready_q   <= ready_d;
            ch_run_q  <= ch_run_d;
`ifdef MINSOC_RST_STAGGER_EN
            stg_q     <= stg_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
`ifdef MINSOC_RST_STAGGER_EN
        stg_d   = stg_q;
`endif
        case (state_q)
            ST_HOLD: begin
                if (sync_q[1]) begin
                    if (hold_q == HC_W'(RST_HOLD - 1)) begin
                        hold_d = '0;
`ifdef MINSOC_RST_STAGGER_EN
                        stg_d   = '0;
                        state_d = ST_STAGGER;
`else
                        state_d = ST_RUN;
`endif
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
`ifdef MINSOC_RST_STAGGER_EN
            ST_STAGGER: begin
                if (stg_q == SG_W'(NUM_CH - 1)) state_d = ST_RUN;
                else                            stg_d   = stg_q + 1'b1;
            end
`endif
            ST_RUN: begin
                if (sw_rst_i) begin
                    state_d = ST_HOLD;
                    hold_d  = '0;
                end
            end
            default: state_d = ST_HOLD;
        endcase
    end

    always_comb begin
        rst_run_d = (state_d != ST_HOLD);
        ready_d   = (state_d == ST_RUN);
        ch_run_d  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
`ifdef MINSOC_RST_STAGGER_EN
            ch_run_d[k] = ready_d || (state_d == ST_STAGGER && int'(stg_d) > k);
`else
            ch_run_d[k] = ready_d;
`endif
        end
    end

    assign rst_o    = RST_POL ? ~rst_run_q : rst_run_q;
    assign rst_ch_o = RST_POL ? ~ch_run_q  : ch_run_q;
    assign ready_o  = ready_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DIV_W-1:0] cnt_q, div_q, div_cur;
        logic             clk_q, tick_q, act_q;
        logic             active, first, wrap;

        // Dividers stop on the same edge a software reset reasserts the channel reset.
        assign active  = ch_run_q[k] & ch_run_d[k] & en_i[k];
        assign first   = active & ~act_q;
        assign div_cur = first ? div_i[k*DIV_W +: DIV_W] : div_q;
        assign wrap    = (cnt_q == div_cur);

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                cnt_q  <= '0;
                div_q  <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
                act_q  <= 1'b0;
            end else if (!active) begin
                cnt_q  <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
                act_q  <= 1'b0;
            end else begin
                act_q  <= 1'b1;
                tick_q <= wrap & clk_q;
                if (wrap) begin
                    cnt_q <= '0;
                    clk_q <= ~clk_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                // New divisor only at a period boundary so no half-period is cut or stretched.
                if (first || (wrap && clk_q)) div_q <= div_i[k*DIV_W +: DIV_W];
            end
        end

        assign clk_o[k]  = clk_q;
        assign tick_o[k] = tick_q;
    end

endmodule

// File: tb/tb_minsoc_clock_reset_ctrl.sv
// Bench for minsoc_clock_reset_ctrl: both reset polarities driven in parallel against an edge-count reference model.
module tb_minsoc_clock_reset_ctrl;
    localparam int NUM_CH   = 2;
    localparam int DIV_W    = 8;
    localparam int RST_HOLD = 16;
    localparam int NEVER    = 1 << 30;
`ifdef MINSOC_RST_STAGGER_EN
    localparam bit STAG = 1'b1;
`else
    localparam bit STAG = 1'b0;
`endif

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic                    sw_rst_i = 1'b0;
    logic [NUM_CH-1:0]       en_i = '0;
    logic [NUM_CH*DIV_W-1:0] div_i = '0;

    logic              rst_o_p, rst_o_n, ready_p, ready_n;
    logic [NUM_CH-1:0] rst_ch_p, rst_ch_n, clk_p, clk_n, tick_p, tick_n;

    always #5 clock = ~clock;

    minsoc_clock_reset_ctrl #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .RST_HOLD(RST_HOLD), .RST_POL(1'b1)) u_dut_p (
        .clock(clock), .reset(reset), .sw_rst_i(sw_rst_i), .en_i(en_i), .div_i(div_i),
        .rst_o(rst_o_p), .rst_ch_o(rst_ch_p), .clk_o(clk_p), .tick_o(tick_p), .ready_o(ready_p));

    minsoc_clock_reset_ctrl #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .RST_HOLD(RST_HOLD), .RST_POL(1'b0)) u_dut_n (
        .clock(clock), .reset(reset), .sw_rst_i(sw_rst_i), .en_i(en_i), .div_i(div_i),
        .rst_o(rst_o_n), .rst_ch_o(rst_ch_n), .clk_o(clk_n), .tick_o(tick_n), .ready_o(ready_n));

    int checks = 0;
    int errors = 0;

    // Reference model: everything is expressed as absolute edge numbers.
    int                n = 0;
    int                deassert_at = NEVER;
    bit                rst_low = 1'b1;
    bit                ready_prev = 1'b0;
    bit [NUM_CH-1:0]   ch_run_prev = '0;
    bit                e_rst_act, e_ready;
    bit [NUM_CH-1:0]   e_ch_act;
    bit [NUM_CH-1:0]   m_clk, m_tick, started;
    int                next_tog [NUM_CH];
    int                curd [NUM_CH];
    logic              exp_rst_p, exp_rst_n;
    logic [NUM_CH-1:0] exp_ch_p, exp_ch_n;

    function automatic int off(int k);
        return STAG ? k + 1 : 0;
    endfunction

    task automatic set_levels();
        exp_rst_p = e_rst_act;
        exp_rst_n = !e_rst_act;
        exp_ch_p  = e_ch_act;
        exp_ch_n  = ~e_ch_act;
    endtask

    task automatic model_clear();
        e_rst_act   = 1'b1;
        e_ch_act    = '1;
        e_ready     = 1'b0;
        m_clk       = '0;
        m_tick      = '0;
        started     = '0;
        ch_run_prev = '0;
        ready_prev  = 1'b0;
        deassert_at = NEVER;
        set_levels();
    endtask

    task automatic model_edge();
        bit [NUM_CH-1:0] ch_run_now;
        bit act;
        int dk;
        if (rst_low) begin
            model_clear();
        end else begin
            if (sw_rst_i && ready_prev) deassert_at = n + RST_HOLD;
            e_rst_act = (n < deassert_at);
            e_ready   = (n >= deassert_at + (STAG ? NUM_CH : 0));
            for (int k = 0; k < NUM_CH; k++) begin
                ch_run_now[k] = (n >= deassert_at + off(k));
                act = ch_run_prev[k] && ch_run_now[k] && en_i[k];
                dk  = int'(div_i[k*DIV_W +: DIV_W]);
                if (!act) begin
                    started[k] = 1'b0;
                    m_clk[k]   = 1'b0;
                    m_tick[k]  = 1'b0;
                end else begin
                    m_tick[k] = 1'b0;
                    if (!started[k]) begin
                        started[k]  = 1'b1;
                        curd[k]     = dk;
                        next_tog[k] = n + dk;
                    end
                    if (n == next_tog[k]) begin
                        if (m_clk[k]) begin
                            m_tick[k] = 1'b1;
                            curd[k]   = dk;
                        end
                        m_clk[k]    = !m_clk[k];
                        next_tog[k] = n + curd[k] + 1;
                    end
                end
            end
            e_ch_act    = ~ch_run_now;
            ch_run_prev = ch_run_now;
            ready_prev  = e_ready;
            set_levels();
        end
    endtask

    task automatic check_bit(string name, logic [7:0] got, logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s at edge %0d: observed %h expected %h", name, n, got, exp);
        end
    endtask

    task automatic check_all();
        check_bit("rst_o_pos",    {7'b0, rst_o_p},                    {7'b0, exp_rst_p});
        check_bit("rst_o_neg",    {7'b0, rst_o_n},                    {7'b0, exp_rst_n});
        check_bit("rst_ch_pos",   {{(8-NUM_CH){1'b0}}, rst_ch_p},     {{(8-NUM_CH){1'b0}}, exp_ch_p});
        check_bit("rst_ch_neg",   {{(8-NUM_CH){1'b0}}, rst_ch_n},     {{(8-NUM_CH){1'b0}}, exp_ch_n});
        check_bit("ready_pos",    {7'b0, ready_p},                    {7'b0, e_ready});
        check_bit("ready_neg",    {7'b0, ready_n},                    {7'b0, e_ready});
        check_bit("clk_pos",      {{(8-NUM_CH){1'b0}}, clk_p},        {{(8-NUM_CH){1'b0}}, m_clk});
        check_bit("clk_neg",      {{(8-NUM_CH){1'b0}}, clk_n},        {{(8-NUM_CH){1'b0}}, m_clk});
        check_bit("tick_pos",     {{(8-NUM_CH){1'b0}}, tick_p},       {{(8-NUM_CH){1'b0}}, m_tick});
        check_bit("tick_neg",     {{(8-NUM_CH){1'b0}}, tick_n},       {{(8-NUM_CH){1'b0}}, m_tick});
    endtask

    task automatic step();
        @(posedge clock);
        n++;
        model_edge();
        #1;
        check_all();
    endtask

    task automatic steps(int cnt);
        for (int i = 0; i < cnt; i++) step();
    endtask

    // Called just after an edge's checks; that edge counts as edge 0 of the release sequence.
    task automatic release_reset();
        reset       = 1'b1;
        rst_low     = 1'b0;
        deassert_at = n + 2 + RST_HOLD;
    endtask

    // Drops reset between edges and checks the outputs before any further clock edge.
    task automatic async_reset();
        #2 reset = 1'b0;
        #1;
        rst_low = 1'b1;
        model_clear();
        check_all();
    endtask

    task automatic set_div(int k, int v);
        div_i[k*DIV_W +: DIV_W] = DIV_W'(v);
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        model_clear();
        check_all();

        // Power-up with div 0 on channel 0 and div 3 on channel 1
        en_i = '1;
        set_div(0, 0);
        set_div(1, 3);
        steps(3);
        release_reset();
        steps(44);

        // Divisor 3 -> 1 while channel 1 is high
        for (int i = 0; i < 20 && !m_clk[1]; i++) step();
        set_div(1, 1);
        steps(30);

        // One-cycle software reset, then held high throughout HOLD
        sw_rst_i = 1'b1;
        step();
        steps(10);
        sw_rst_i = 1'b0;
        steps(30);

        // Board reset dropped mid-HOLD
        sw_rst_i = 1'b1;
        step();
        sw_rst_i = 1'b0;
        steps(5);
        async_reset();
        steps(3);
        release_reset();
        steps(30);

        // Board reset dropped mid-RUN
        async_reset();
        steps(2);
        release_reset();
        steps(30);

        // Randomised enables, divisors and reset requests
        for (int i = 0; i < 2000; i++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if ($urandom_range(0, 24) == 0) en_i[k] = ~en_i[k];
                if ($urandom_range(0, 29) == 0) set_div(k, int'($urandom_range(0, 5)));
            end
            sw_rst_i = ($urandom_range(0, 119) == 0);
            if (!rst_low && $urandom_range(0, 499) == 0) begin
                async_reset();
                steps(int'($urandom_range(1, 3)));
                release_reset();
            end
            step();
        end
        sw_rst_i = 1'b0;
        steps(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
